// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared sizes, entry layout and CDB operand snoop
package reservation_station_pkg;
  localparam int RS_SIZE = 16;
  localparam int IDX_W = 4;
  localparam int ROB_W = 4;
  localparam int XLEN = 32;
  localparam int TYPE_W = 6;
  localparam logic [ROB_W-1:0] NULL_TAG = '0;
  typedef struct packed {
    logic [ROB_W-1:0] q;
    logic [XLEN-1:0] v;
  } opnd_t;
  typedef struct packed {
    logic [TYPE_W-1:0] op;
    opnd_t j;
    opnd_t k;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [ROB_W-1:0] dest;
  } entry_t;
  // a waiting operand takes whichever CDB carries its producer tag
  function automatic opnd_t snoop(input opnd_t o, input logic ae, input logic [ROB_W-1:0] at,
                                  input logic [XLEN-1:0] ad, input logic le,
                                  input logic [ROB_W-1:0] lt, input logic [XLEN-1:0] ld);
    return o.q == NULL_TAG ? o :
           (ae && o.q == at) ? opnd_t'{NULL_TAG, ad} :
           (le && o.q == lt) ? opnd_t'{NULL_TAG, ld} : o;
  endfunction
endpackage

// File: rtl/reservation_station_find_first.sv
// reservation_station_find_first: lowest set bit of an RS_SIZE-bit vector
module reservation_station_find_first
  import reservation_station_pkg::*;
(
  input  logic [RS_SIZE-1:0] vec,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);
  always_comb begin
    found = |vec;
    idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (vec[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds dispatched ALU instructions until operands are ready,
// snoops ALU/LSB CDBs and issues the lowest-index ready entry each cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              en_in,
  input  logic [TYPE_W-1:0] inst_type_in,
  input  logic [XLEN-1:0]   vj_in,
  input  logic [XLEN-1:0]   vk_in,
  input  logic [ROB_W-1:0]  qj_in,
  input  logic [ROB_W-1:0]  qk_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [ROB_W-1:0]  dest_in,
  input  logic [XLEN-1:0]   pc_in,
  output logic              full_out,
  input  logic              alu_cdb_en_in,
  input  logic [ROB_W-1:0]  alu_cdb_tag_in,
  input  logic [XLEN-1:0]   alu_cdb_data_in,
  input  logic              lsb_cdb_en_in,
  input  logic [ROB_W-1:0]  lsb_cdb_tag_in,
  input  logic [XLEN-1:0]   lsb_cdb_data_in,
  output logic              alu_en_out,
  output logic [TYPE_W-1:0] alu_type_out,
  output logic [XLEN-1:0]   alu_vj_out,
  output logic [XLEN-1:0]   alu_vk_out,
  output logic [XLEN-1:0]   alu_imm_out,
  output logic [XLEN-1:0]   alu_pc_out,
  output logic [ROB_W-1:0]  alu_dest_out
);
  logic [RS_SIZE-1:0] busy, ready;
  entry_t ent [RS_SIZE];
  opnd_t snj [RS_SIZE];
  opnd_t snk [RS_SIZE];
  opnd_t din_j, din_k;
  logic free_found, rdy_found;
  logic [IDX_W-1:0] free_idx, rdy_idx;
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] && ent[i].j.q == NULL_TAG && ent[i].k.q == NULL_TAG;
      snj[i] = snoop(ent[i].j, alu_cdb_en_in, alu_cdb_tag_in, alu_cdb_data_in, lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_data_in);
      snk[i] = snoop(ent[i].k, alu_cdb_en_in, alu_cdb_tag_in, alu_cdb_data_in, lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_data_in);
    end
  end
  assign din_j = snoop(opnd_t'{qj_in, vj_in}, alu_cdb_en_in, alu_cdb_tag_in, alu_cdb_data_in, lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_data_in);
  assign din_k = snoop(opnd_t'{qk_in, vk_in}, alu_cdb_en_in, alu_cdb_tag_in, alu_cdb_data_in, lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_data_in);
  // one slot of slack so a dispatch accepted while not full always lands
  assign full_out = $countones(busy) >= RS_SIZE - 1;
  reservation_station_find_first u_free (.vec(~busy), .found(free_found), .idx(free_idx));
  reservation_station_find_first u_ready (.vec(ready), .found(rdy_found), .idx(rdy_idx));
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy <= '0;
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      alu_en_out <= 1'b0;
      alu_type_out <= '0;
      alu_vj_out <= '0;
      alu_vk_out <= '0;
      alu_imm_out <= '0;
      alu_pc_out <= '0;
      alu_dest_out <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        busy <= '0;
        alu_en_out <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++)
          if (busy[i]) begin
            ent[i].j <= snj[i];
            ent[i].k <= snk[i];
          end
        alu_en_out <= rdy_found;
        if (rdy_found) begin
          busy[rdy_idx] <= 1'b0;
          alu_type_out <= ent[rdy_idx].op;
          alu_vj_out <= ent[rdy_idx].j.v;
          alu_vk_out <= ent[rdy_idx].k.v;
          alu_imm_out <= ent[rdy_idx].imm;
          alu_pc_out <= ent[rdy_idx].pc;
          alu_dest_out <= ent[rdy_idx].dest;
        end
        if (en_in && free_found) begin
          busy[free_idx] <= 1'b1;
          ent[free_idx] <= '{op: inst_type_in, j: din_j, k: din_k, imm: imm_in, pc: pc_in, dest: dest_in};
        end
      end
    end
  end
  a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
    (rdy_in && !clear_in && en_in) |-> free_found);
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus random traffic, checked every
// cycle against a slot-array model of the station.
module tb_reservation_station;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in, clear_in, en_in;
  logic [5:0] inst_type_in;
  logic [31:0] vj_in, vk_in, imm_in, pc_in;
  logic [3:0] qj_in, qk_in, dest_in;
  logic full_out;
  logic alu_cdb_en_in, lsb_cdb_en_in;
  logic [3:0] alu_cdb_tag_in, lsb_cdb_tag_in;
  logic [31:0] alu_cdb_data_in, lsb_cdb_data_in;
  logic alu_en_out;
  logic [5:0] alu_type_out;
  logic [31:0] alu_vj_out, alu_vk_out, alu_imm_out, alu_pc_out;
  logic [3:0] alu_dest_out;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in), .en_in(en_in),
    .inst_type_in(inst_type_in), .vj_in(vj_in), .vk_in(vk_in), .qj_in(qj_in), .qk_in(qk_in),
    .imm_in(imm_in), .dest_in(dest_in), .pc_in(pc_in), .full_out(full_out),
    .alu_cdb_en_in(alu_cdb_en_in), .alu_cdb_tag_in(alu_cdb_tag_in), .alu_cdb_data_in(alu_cdb_data_in),
    .lsb_cdb_en_in(lsb_cdb_en_in), .lsb_cdb_tag_in(lsb_cdb_tag_in), .lsb_cdb_data_in(lsb_cdb_data_in),
    .alu_en_out(alu_en_out), .alu_type_out(alu_type_out), .alu_vj_out(alu_vj_out),
    .alu_vk_out(alu_vk_out), .alu_imm_out(alu_imm_out), .alu_pc_out(alu_pc_out),
    .alu_dest_out(alu_dest_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  bit m_busy [16];
  logic [3:0] m_qj [16], m_qk [16], m_dest [16];
  logic [31:0] m_vj [16], m_vk [16], m_imm [16], m_pc [16];
  logic [5:0] m_op [16];
  logic e_en;
  logic [5:0] e_op;
  logic [31:0] e_vj, e_vk, e_imm, e_pc;
  logic [3:0] e_dest;

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 0; m_qj[i] = 0; m_qk[i] = 0; m_dest[i] = 0;
      m_vj[i] = 0; m_vk[i] = 0; m_imm[i] = 0; m_pc[i] = 0; m_op[i] = 0;
    end
    e_en = 0; e_op = 0; e_vj = 0; e_vk = 0; e_imm = 0; e_pc = 0; e_dest = 0;
  endtask

  task automatic resolve(inout logic [3:0] q, inout logic [31:0] v);
    if (q != 0 && alu_cdb_en_in && q == alu_cdb_tag_in) begin q = 0; v = alu_cdb_data_in; end
    else if (q != 0 && lsb_cdb_en_in && q == lsb_cdb_tag_in) begin q = 0; v = lsb_cdb_data_in; end
  endtask

  // one clock edge of the station, from the pre-edge contents and current inputs
  task automatic model_step();
    int iss, fr;
    logic [3:0] q;
    logic [31:0] v;
    if (!rdy_in) return;
    if (clear_in) begin
      for (int i = 0; i < 16; i++) m_busy[i] = 0;
      e_en = 0;
      return;
    end
    iss = -1; fr = -1;
    for (int i = 0; i < 16; i++) begin
      if (iss < 0 && m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) iss = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    for (int i = 0; i < 16; i++)
      if (m_busy[i]) begin
        q = m_qj[i]; v = m_vj[i]; resolve(q, v); m_qj[i] = q; m_vj[i] = v;
        q = m_qk[i]; v = m_vk[i]; resolve(q, v); m_qk[i] = q; m_vk[i] = v;
      end
    e_en = iss >= 0;
    if (iss >= 0) begin
      e_op = m_op[iss]; e_vj = m_vj[iss]; e_vk = m_vk[iss];
      e_imm = m_imm[iss]; e_pc = m_pc[iss]; e_dest = m_dest[iss];
      m_busy[iss] = 0;
    end
    if (en_in && fr >= 0) begin
      q = qj_in; v = vj_in; resolve(q, v); m_qj[fr] = q; m_vj[fr] = v;
      q = qk_in; v = vk_in; resolve(q, v); m_qk[fr] = q; m_vk[fr] = v;
      m_op[fr] = inst_type_in; m_imm[fr] = imm_in; m_pc[fr] = pc_in; m_dest[fr] = dest_in;
      m_busy[fr] = 1;
    end
  endtask

  always @(negedge clk_in) if (chk_on) begin
    checks++;
    if ({alu_en_out, alu_type_out, alu_vj_out, alu_vk_out, alu_imm_out, alu_pc_out, alu_dest_out} !==
        {e_en, e_op, e_vj, e_vk, e_imm, e_pc, e_dest}) begin
      errors++;
      $display("FAIL issue @%0t: got en=%0b op=%0h vj=%0h vk=%0h imm=%0h pc=%0h dest=%0d, want en=%0b op=%0h vj=%0h vk=%0h imm=%0h pc=%0h dest=%0d",
               $time, alu_en_out, alu_type_out, alu_vj_out, alu_vk_out, alu_imm_out, alu_pc_out, alu_dest_out,
               e_en, e_op, e_vj, e_vk, e_imm, e_pc, e_dest);
    end
    checks++;
    if (full_out !== (mcount() >= 15)) begin
      errors++;
      $display("FAIL full @%0t: got %0b want %0b (count %0d)", $time, full_out, mcount() >= 15, mcount());
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, got, exp);
    end
  endtask

  task automatic idle();
    rdy_in = 1; clear_in = 0; en_in = 0; alu_cdb_en_in = 0; lsb_cdb_en_in = 0;
    qj_in = 0; qk_in = 0;
  endtask

  task automatic set_disp(input logic [3:0] qj, input logic [3:0] qk, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [3:0] dest);
    en_in = 1; qj_in = qj; qk_in = qk; vj_in = vj; vk_in = vk; dest_in = dest;
    inst_type_in = 6'($urandom); imm_in = $urandom; pc_in = $urandom;
  endtask

  task automatic cdb_alu(input logic [3:0] t, input logic [31:0] d);
    alu_cdb_en_in = 1; alu_cdb_tag_in = t; alu_cdb_data_in = d;
  endtask

  task automatic step();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
  endtask

  initial begin
    idle();
    inst_type_in = 0; vj_in = 0; vk_in = 0; imm_in = 0; pc_in = 0; dest_in = 0;
    alu_cdb_tag_in = 0; alu_cdb_data_in = 0; lsb_cdb_tag_in = 0; lsb_cdb_data_in = 0;
    m_reset();
    #1 rst_in = 0;
    chk_on = 1;
    repeat (2) @(negedge clk_in);
    chk("reset_en", 32'(alu_en_out), 0);
    chk("reset_full", 32'(full_out), 0);
    chk("reset_vj", alu_vj_out, 0);
    rst_in = 1;

    set_disp(0, 0, 5, 7, 3);
    step(); idle();
    chk("ready_not_yet", 32'(alu_en_out), 0);
    step();
    chk("ready_en", 32'(alu_en_out), 1);
    chk("ready_vj", alu_vj_out, 5);
    chk("ready_vk", alu_vk_out, 7);
    chk("ready_dest", 32'(alu_dest_out), 3);
    step();
    chk("ready_pulse", 32'(alu_en_out), 0);

    set_disp(2, 4, 0, 0, 5);
    step(); idle();
    cdb_alu(2, 32'h10);
    step(); idle();
    lsb_cdb_en_in = 1; lsb_cdb_tag_in = 4; lsb_cdb_data_in = 32'h20;
    step(); idle();
    chk("wake_wait", 32'(alu_en_out), 0);
    step();
    chk("wake_en", 32'(alu_en_out), 1);
    chk("wake_vj", alu_vj_out, 32'h10);
    chk("wake_vk", alu_vk_out, 32'h20);

    set_disp(6, 0, 0, 1, 6);
    cdb_alu(6, 32'hAB);
    step(); idle();
    step();
    chk("bypass_en", 32'(alu_en_out), 1);
    chk("bypass_vj", alu_vj_out, 32'hAB);
    step(); step();

    for (int i = 0; i < 15; i++) begin
      set_disp(9, 0, 32'(i), 0, 4'(i));
      step();
      if (i == 13) chk("full_at_14", 32'(full_out), 0);
    end
    idle();
    chk("full_at_15", 32'(full_out), 1);
    cdb_alu(9, 32'h99);
    step(); idle();
    for (int k = 0; k < 15; k++) begin
      step();
      chk("order_en", 32'(alu_en_out), 1);
      chk("order_dest", 32'(alu_dest_out), 32'(k));
      chk("order_vj", alu_vj_out, 32'h99);
      if (k == 0) chk("full_drop", 32'(full_out), 0);
    end
    step();
    chk("drained", 32'(alu_en_out), 0);

    for (int i = 0; i < 4; i++) begin
      set_disp(7, 0, 0, 0, 4'(i));
      step();
    end
    set_disp(0, 0, 1, 2, 8);
    clear_in = 1;
    cdb_alu(7, 32'h77);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      cdb_alu(7, 32'h77);
      step();
      chk("flush_no_issue", 32'(alu_en_out), 0);
      chk("flush_full", 32'(full_out), 0);
    end
    idle();

    for (int i = 0; i < 5; i++) begin
      set_disp(11, 0, 0, 0, 4'(i));
      step();
    end
    idle();
    #2 rst_in = 0;
    #1;
    chk("async_rst_en", 32'(alu_en_out), 0);
    chk("async_rst_full", 32'(full_out), 0);
    m_reset();
    @(negedge clk_in);
    rst_in = 1;
    cdb_alu(11, 32'h11);
    step(); idle();
    step();
    chk("rst_cleared", 32'(alu_en_out), 0);

    for (int n = 0; n < 3000; n++) begin
      rdy_in = $urandom_range(0, 4) != 0;
      clear_in = $urandom_range(0, 60) == 0;
      en_in = (mcount() < 15) && ($urandom_range(0, 2) != 0);
      qj_in = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      qk_in = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      vj_in = $urandom; vk_in = $urandom; imm_in = $urandom; pc_in = $urandom;
      dest_in = 4'($urandom); inst_type_in = 6'($urandom);
      alu_cdb_en_in = $urandom_range(0, 2) == 0;
      alu_cdb_tag_in = 4'($urandom_range(1, 15));
      alu_cdb_data_in = $urandom;
      lsb_cdb_en_in = $urandom_range(0, 2) == 0;
      lsb_cdb_tag_in = 4'($urandom_range(1, 15));
      if (lsb_cdb_tag_in == alu_cdb_tag_in) lsb_cdb_tag_in = lsb_cdb_tag_in == 15 ? 4'd1 : lsb_cdb_tag_in + 4'd1;
      lsb_cdb_data_in = $urandom;
      step();
    end
    idle();
    repeat (20) step();
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
